// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding, frame length
// and baud divisors for a 50 MHz clock.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  localparam int FRAME_TICKS_DEF = 16;

  localparam int BAUD_DIV_115200  = 434;
  localparam int BAUD_DIV_230400  = 217;
  localparam int BAUD_DIV_460800  = 109;
  localparam int BAUD_DIV_691200  = 72;
  localparam int BAUD_DIV_1382400 = 36;

  // Explicit modulo wrap so NUM_REQ need not be a power of two
  function automatic int rr_next(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester/transmitter bundle of the UART TX scheduler.
// master: client + transmitter side, slave: scheduler.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_pbit_en;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_pbit_en;
  logic                      tx_frame_start;
  logic                      tx_active;
  logic                      frame_done;
  logic [GW-1:0]             grant_id;

  modport master (
    output req_valid, req_data, req_pbit_en,
    input  req_ready, tx_data, tx_pbit_en,
    input  tx_frame_start, tx_active,
    input  frame_done, grant_id
  );

  modport slave (
    input  req_valid, req_data, req_pbit_en,
    output req_ready, tx_data, tx_pbit_en,
    output tx_frame_start, tx_active,
    output frame_done, grant_id
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first valid index at or
// after the pointer, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [GW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [GW-1:0]      idx,
  output logic               any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && valid[j]) begin
        any      = 1'b1;
        idx      = GW'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART TX frame datapath among
// NUM_REQ byte requesters, sequenced on the baud tick.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int FRAME_TICKS = FRAME_TICKS_DEF,
  parameter int GAP_TICKS   = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic baud_tick,
  input  logic rx_abort,
  uart_tx_scheduler_if.slave bus
);

  localparam int GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAXT = (FRAME_TICKS > GAP_TICKS) ?
                        FRAME_TICKS : GAP_TICKS;
  localparam int CW   = $clog2(MAXT + 1);
  localparam logic [CW-1:0] F_LAST = CW'(FRAME_TICKS - 1);
  localparam logic [CW-1:0] G_LAST =
    CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  tx_state_e         state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [GW-1:0]     ptr, ptr_nx;
  logic [DATA_W-1:0] data_q, data_nx;
  logic              pbit_q, pbit_nx;
  logic              act_q, act_nx;
  logic              fs_q, fs_nx;
  logic              done_q, done_nx;
  logic [GW-1:0]     gid_q, gid_nx;
  logic              arb;

  logic [NUM_REQ-1:0] g_oh;
  logic [GW-1:0]      g_idx;
  logic               g_any;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .valid(bus.req_valid),
    .ptr  (ptr),
    .grant(g_oh),
    .idx  (g_idx),
    .any  (g_any)
  );

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    ptr_nx        = ptr;
    data_nx       = data_q;
    pbit_nx       = pbit_q;
    act_nx        = act_q;
    gid_nx        = gid_q;
    fs_nx         = 1'b0;
    done_nx       = 1'b0;
    arb           = 1'b0;
    bus.req_ready = '0;
    if (baud_tick) begin
      unique case (state)
        IDLE: arb = 1'b1;
        SEND: begin
          if (rx_abort) begin
            state_nx = IDLE;
            act_nx   = 1'b0;
          end else if (cnt == F_LAST) begin
            done_nx = 1'b1;
            if (GAP_TICKS > 0) begin
              state_nx = GAP;
              cnt_nx   = '0;
              act_nx   = 1'b0;
            end else begin
              arb = 1'b1;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        GAP: begin
          if (rx_abort) begin
            state_nx = IDLE;
            act_nx   = 1'b0;
          end else if (cnt == G_LAST) begin
            arb = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
    // Terminating tick doubles as the next transfer cycle
    if (arb) begin
      if (g_any) begin
        bus.req_ready = g_oh;
        data_nx  = bus.req_data[g_idx*DATA_W +: DATA_W];
        pbit_nx  = bus.req_pbit_en[g_idx];
        gid_nx   = g_idx;
        ptr_nx   = GW'(rr_next(int'(g_idx), NUM_REQ));
        cnt_nx   = '0;
        state_nx = SEND;
        act_nx   = 1'b1;
        fs_nx    = 1'b1;
      end else begin
        state_nx = IDLE;
        act_nx   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ptr    <= '0;
      data_q <= '0;
      pbit_q <= 1'b0;
      act_q  <= 1'b0;
      fs_q   <= 1'b0;
      done_q <= 1'b0;
      gid_q  <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      ptr    <= ptr_nx;
      data_q <= data_nx;
      pbit_q <= pbit_nx;
      act_q  <= act_nx;
      fs_q   <= fs_nx;
      done_q <= done_nx;
      gid_q  <= gid_nx;
    end
  end

  assign bus.tx_data        = data_q;
  assign bus.tx_pbit_en     = pbit_q;
  assign bus.tx_active      = act_q;
  assign bus.tx_frame_start = fs_q;
  assign bus.frame_done     = done_q;
  assign bus.grant_id       = gid_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: one instance without
// and one with an inter-frame gap, sharing clock and baud tick.
module tb_uart_tx_scheduler;

  localparam int NR = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic baud_tick = 1'b0;
  logic rx_abort = 1'b0;

  always #10 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) ia ();
  uart_tx_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) ib ();

  uart_tx_scheduler #(
    .NUM_REQ(NR), .DATA_W(DW), .FRAME_TICKS(16), .GAP_TICKS(0)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .rx_abort(rx_abort), .bus(ia)
  );

  uart_tx_scheduler #(
    .NUM_REQ(NR), .DATA_W(DW), .FRAME_TICKS(16), .GAP_TICKS(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .rx_abort(rx_abort), .bus(ib)
  );

  int errors = 0;
  int checks = 0;
  int done_a = 0;
  int fs_a   = 0;
  int base_d;
  int base_f;
  logic [NR-1:0] rdy_a;
  logic [NR-1:0] rdy_b;

  always @(posedge clk) begin
    if (ia.frame_done) done_a++;
    if (ia.tx_frame_start) fs_a++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic abort);
    @(negedge clk);
    baud_tick = 1'b1;
    rx_abort  = abort;
    #1;
    rdy_a = ia.req_ready;
    rdy_b = ib.req_ready;
    @(negedge clk);
    baud_tick = 1'b0;
    rx_abort  = 1'b0;
  endtask

  task automatic wait_grant(input bit on_b, input int exp_g,
                            input int exp_n, input string tag);
    int n;
    logic [NR-1:0] r;
    n = 0;
    r = '0;
    while (r == '0 && n < 40) begin
      tick(1'b0);
      n++;
      r = on_b ? rdy_b : rdy_a;
    end
    check($sformatf("%s_rdy", tag), 32'(r), 32'(1) << exp_g);
    check($sformatf("%s_ticks", tag), n, exp_n);
  endtask

  initial begin
    ia.req_valid = '0; ia.req_data = '0; ia.req_pbit_en = '0;
    ib.req_valid = '0; ib.req_data = '0; ib.req_pbit_en = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_data", ia.tx_data, 0);
    check("rst_pbit", ia.tx_pbit_en, 0);
    check("rst_act", ia.tx_active, 0);
    check("rst_gid", ia.grant_id, 0);
    check("rst_fs", ia.tx_frame_start, 0);
    check("rst_done", ia.frame_done, 0);

    // single request
    ia.req_data[2*DW +: DW] = 8'hA5;
    ia.req_pbit_en[2] = 1'b1;
    ia.req_valid[2] = 1'b1;
    base_d = done_a;
    base_f = fs_a;
    wait_grant(1'b0, 2, 1, "single");
    ia.req_valid = '0;
    check("single_fs", ia.tx_frame_start, 1);
    check("single_act", ia.tx_active, 1);
    check("single_data", ia.tx_data, 8'hA5);
    check("single_pbit", ia.tx_pbit_en, 1);
    check("single_gid", ia.grant_id, 2);
    repeat (15) tick(1'b0);
    check("single_act15", ia.tx_active, 1);
    check("single_data15", ia.tx_data, 8'hA5);
    check("single_pbit15", ia.tx_pbit_en, 1);
    check("single_nodone15", done_a - base_d, 0);
    tick(1'b0);
    check("single_act16", ia.tx_active, 0);
    check("single_done", ia.frame_done, 1);
    check("single_keep", ia.tx_data, 8'hA5);
    @(negedge clk);
    check("single_ndone", done_a - base_d, 1);
    check("single_nfs", fs_a - base_f, 1);

    // fairness from a fresh pointer
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NR; i++)
      ia.req_data[i*DW +: DW] = DW'(8'h10 + i);
    ia.req_pbit_en = 4'b0101;
    ia.req_valid = 4'b1111;
    wait_grant(1'b0, 0, 1, "fair0");
    check("fair0_data", ia.tx_data, 8'h10);
    for (int i = 1; i <= 4; i++) begin
      wait_grant(1'b0, i % 4, 16, $sformatf("fair%0d", i));
      check($sformatf("fair%0d_gid", i), ia.grant_id, i % 4);
      check($sformatf("fair%0d_data", i), ia.tx_data,
            8'h10 + (i % 4));
    end

    // pointer rotation
    ia.req_valid = 4'b0010;
    wait_grant(1'b0, 1, 16, "rot1");
    ia.req_valid = 4'b1001;
    wait_grant(1'b0, 3, 16, "rot3");
    check("rot3_pbit", ia.tx_pbit_en, 0);
    wait_grant(1'b0, 0, 16, "rot0");
    check("rot0_pbit", ia.tx_pbit_en, 1);
    ia.req_valid = '0;
    repeat (16) tick(1'b0);
    check("rot_idle", ia.tx_active, 0);

    // abort mid-frame
    ia.req_valid = 4'b1000;
    wait_grant(1'b0, 3, 1, "abg");
    ia.req_valid = '0;
    repeat (6) tick(1'b0);
    ia.req_valid = 4'b0010;
    base_d = done_a;
    tick(1'b1);
    check("abort_rdy", 32'(rdy_a), 0);
    check("abort_act", ia.tx_active, 0);
    tick(1'b0);
    check("abort_regrant", 32'(rdy_a), 4'b0010);
    check("abort_gid", ia.grant_id, 1);
    check("abort_act2", ia.tx_active, 1);
    @(negedge clk);
    check("abort_nodone", done_a - base_d, 0);
    ia.req_valid = '0;
    repeat (16) tick(1'b0);

    // abort while idle is ignored
    ia.req_valid = 4'b0100;
    tick(1'b1);
    check("idle_abort", 32'(rdy_a), 4'b0100);
    ia.req_valid = '0;
    check("idle_abort_data", ia.tx_data, 8'h12);

    // async reset mid-frame at tick 9
    repeat (8) tick(1'b0);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mrst_data", ia.tx_data, 0);
    check("mrst_pbit", ia.tx_pbit_en, 0);
    check("mrst_act", ia.tx_active, 0);
    check("mrst_gid", ia.grant_id, 0);
    check("mrst_fs", ia.tx_frame_start, 0);
    check("mrst_done", ia.frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ia.req_valid = 4'b1011;
    wait_grant(1'b0, 0, 1, "post_rst");
    ia.req_valid = '0;
    repeat (16) tick(1'b0);

    // inter-frame gap on the second instance
    ib.req_data[DW-1:0] = 8'h3C;
    ib.req_pbit_en = 4'b0001;
    ib.req_valid = 4'b0001;
    wait_grant(1'b1, 0, 1, "gap0");
    check("gap0_data", ib.tx_data, 8'h3C);
    repeat (15) tick(1'b0);
    check("gap_act15", ib.tx_active, 1);
    tick(1'b0);
    check("gap_act_drop", ib.tx_active, 0);
    check("gap_done", ib.frame_done, 1);
    wait_grant(1'b1, 0, 2, "gap_next");
    check("gap_act_again", ib.tx_active, 1);
    check("gap_fs", ib.tx_frame_start, 1);
    ib.req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
